mem_stage: RTL and testbench
============================

# mem_stage

Memory-access stage of the filter processor pipeline, directly downstream of the EXE/MEM pipeline register. It consumes that register's control word, ALU result, store data, destination register address and Robj value. It performs loads and stores through a req/ack data-memory port, stalling the upstream pipeline registers while an access is in flight. Its registered outputs feed the MEM/WB register and the writeback path.

## Interface
- ADDR_W, 16, data-memory word-address width; `mem_addr = i_alu[ADDR_W-1:0]`
- TIMEOUT, 255, maximum WAIT cycles without `mem_ack` before the access is abandoned (range 1..255)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset; asynchronous, active-high
- i_ctrl  in  17  control word; bit0 memRead, bit1 memWrite, bit2 regWrite, bit3 memToReg, bits16:4 pass-through
- i_srcReg  in  32  store data
- i_srcRegDir  in  4  destination register address
- i_alu  in  32  ALU result / memory address
- i_Robj  in  32  Robj value, passed through
- mem_req  out  1  memory request, registered
- mem_we  out  1  1 = write, registered
- mem_addr  out  ADDR_W  word address, registered
- mem_wdata  out  32  write data, registered
- mem_ack  in  1  memory completion; sampled only in WAIT
- mem_rdata  in  32  read data; valid when mem_ack = 1
- o_stall  out  1  combinational; wired to the active-low EN of upstream pipeline registers (1 = hold)
- o_ctrl  out  17  registered i_ctrl
- o_wbData  out  32  writeback data
- o_wbDir  out  4  writeback register address
- o_wbEn  out  1  writeback enable
- o_Robj  out  32  registered i_Robj
- o_err  out  1  sticky timeout flag

## Operation
- memOp = i_ctrl[0] | i_ctrl[1]. If both bits are set, the operation is treated as a write.
- State machine:
  - IDLE: on memOp, latch mem_addr, mem_wdata and mem_we, then go to WAIT. Otherwise stay in IDLE.
  - WAIT: mem_req = 1.
    - On mem_ack, latch mem_rdata into rdata_q, clear mem_req, go to DONE.
    - When the cycle counter reaches TIMEOUT-1 without an ack, set o_err, set rdata_q = 0, clear mem_req, go to DONE.
  - DONE: unconditionally go to IDLE.
- o_stall = (IDLE & memOp) | WAIT. It is 0 in DONE, so the upstream register advances on that edge.
- Output register update, every clock edge:
  - IDLE with no memOp: o_wbData = i_alu, o_wbEn = i_ctrl[2].
  - IDLE with memOp, and WAIT: bubble, o_wbEn = 0.
  - DONE: o_wbEn = i_ctrl[2]; o_wbData = i_ctrl[3] ? rdata_q : i_alu.
  - o_wbDir, o_ctrl and o_Robj load from their inputs on every non-bubble capture; in bubble cycles they hold.
- The cycle counter is 8 bits, cleared on entry to WAIT.
- o_err stays set until rst.
- mem_ack outside WAIT is ignored.

## Timing
- Reset (async): state IDLE; mem_req, mem_we, mem_addr, mem_wdata = 0; all o_* outputs = 0; counter = 0; rdata_q = 0.
- Non-memory op: result appears on o_wb* one edge after it is presented; no stall.
- Memory op with ack in the first WAIT cycle:
  - o_stall is high for 2 cycles (IDLE, WAIT).
  - Result appears after the 3rd edge.
  - The next instruction is accepted at the DONE edge.
- Each extra WAIT cycle adds one stall cycle.
- Timeout: DONE is entered after TIMEOUT WAIT cycles.
- Back-to-back memory ops: DONE→IDLE, then the new op stalls immediately. There is no lost or duplicated writeback.
- rst asserted in WAIT: mem_req drops asynchronously and the pending access is abandoned. The memory must tolerate a withdrawn request.

## Test plan
- Reset → every output is 0 and o_stall = 0. Then ALU op, i_alu = 0x12345678, regWrite, dir = 5 → next edge: o_wbData = 0x12345678, o_wbDir = 5, o_wbEn = 1.
- Load with i_alu = 0x0040, memToReg, ack after 1 cycle, rdata = 0xCAFEF00D:
  - mem_addr = 0x0040, mem_we = 0.
  - o_stall high for exactly 2 cycles.
  - o_wbData = 0xCAFEF00D, o_wbEn = 1 after the 3rd edge.
  - o_wbEn = 0 in the bubble cycles.
- Store with i_srcReg = 0xDEADBEEF, ack delayed 4 cycles:
  - mem_we = 1, mem_wdata = 0xDEADBEEF, mem_req held for 4 cycles.
  - o_stall high for 5 cycles, o_wbEn = 0 throughout.
- Load followed by a dependent ALU op, then a second load → each writeback occurs exactly once, in order, with correct dir.
- Timeout: TIMEOUT = 4, no ack → mem_req drops after 4 WAIT cycles, o_err = 1 (sticky), o_wbData = 0.
- rst pulsed mid-WAIT → mem_req = 0 immediately, state IDLE, o_stall = 0, o_err = 0.

Source files
------------

// File: rtl/mem_stage.sv
// Memory-access stage: issues loads/stores over a req/ack port, stalls upstream
// while an access is outstanding, and registers the writeback result for MEM/WB.
module mem_stage #(
    parameter int ADDR_W  = 16,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [16:0]       i_ctrl,
    input  logic [31:0]       i_srcReg,
    input  logic [3:0]        i_srcRegDir,
    input  logic [31:0]       i_alu,
    input  logic [31:0]       i_Robj,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ack,
    input  logic [31:0]       mem_rdata,
    output logic              o_stall,
    output logic [16:0]       o_ctrl,
    output logic [31:0]       o_wbData,
    output logic [3:0]        o_wbDir,
    output logic              o_wbEn,
    output logic [31:0]       o_Robj,
    output logic              o_err
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

    state_t      state;
    state_t      next_state;
    logic [7:0]  cnt;
    logic [31:0] rdata_q;
    logic        mem_op;
    logic        wait_end;

    assign mem_op   = i_ctrl[0] | i_ctrl[1];
    assign wait_end = mem_ack || (cnt == LAST_CNT);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Stall is low in DONE so the upstream register advances on the same edge
    // that writes the memory result back.
    always_comb begin
        next_state = state;
        o_stall    = 1'b0;
        case (state)
            S_IDLE: begin
                if (mem_op) begin
                    o_stall    = 1'b1;
                    next_state = S_WAIT;
                end
            end
            S_WAIT: begin
                o_stall = 1'b1;
                if (wait_end) begin
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                next_state = S_IDLE;
            end
            default: begin
                next_state = S_IDLE;
            end
        endcase
    end

    // Memory port, wait counter and captured read data; ack has priority over timeout.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cnt       <= '0;
            rdata_q   <= '0;
            o_err     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        mem_req   <= 1'b1;
                        mem_we    <= i_ctrl[1];
                        mem_addr  <= i_alu[ADDR_W-1:0];
                        mem_wdata <= i_srcReg;
                        cnt       <= '0;
                    end
                end
                S_WAIT: begin
                    if (mem_ack) begin
                        rdata_q <= mem_rdata;
                        mem_req <= 1'b0;
                    end else if (cnt == LAST_CNT) begin
                        o_err   <= 1'b1;
                        rdata_q <= '0;
                        mem_req <= 1'b0;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Writeback register: captures in IDLE without a memory op and in DONE,
    // otherwise emits a bubble and holds the rest.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            o_ctrl   <= '0;
            o_wbData <= '0;
            o_wbDir  <= '0;
            o_wbEn   <= 1'b0;
            o_Robj   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (mem_op) begin
                        o_wbEn <= 1'b0;
                    end else begin
                        o_wbData <= i_alu;
                        o_wbEn   <= i_ctrl[2];
                        o_wbDir  <= i_srcRegDir;
                        o_ctrl   <= i_ctrl;
                        o_Robj   <= i_Robj;
                    end
                end
                S_DONE: begin
                    o_wbData <= i_ctrl[3] ? rdata_q : i_alu;
                    o_wbEn   <= i_ctrl[2];
                    o_wbDir  <= i_srcRegDir;
                    o_ctrl   <= i_ctrl;
                    o_Robj   <= i_Robj;
                end
                default: begin
                    o_wbEn <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: a driver pushes expected writebacks, a
// monitor pops and compares them, and a memory model answers with set latency.
module tb_mem_stage;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [16:0] i_ctrl;
    logic [31:0] i_srcReg;
    logic [3:0]  i_srcRegDir;
    logic [31:0] i_alu;
    logic [31:0] i_Robj;
    logic        mem_req;
    logic        mem_we;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'h0;
    logic        o_stall;
    logic [16:0] o_ctrl;
    logic [31:0] o_wbData;
    logic [3:0]  o_wbDir;
    logic        o_wbEn;
    logic [31:0] o_Robj;
    logic        o_err;

    mem_stage #(.ADDR_W(16), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst(rst),
        .i_ctrl(i_ctrl), .i_srcReg(i_srcReg), .i_srcRegDir(i_srcRegDir),
        .i_alu(i_alu), .i_Robj(i_Robj),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .o_stall(o_stall), .o_ctrl(o_ctrl), .o_wbData(o_wbData),
        .o_wbDir(o_wbDir), .o_wbEn(o_wbEn), .o_Robj(o_Robj), .o_err(o_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  dir;
        logic [16:0] ctrl;
        logic [31:0] robj;
    } wb_t;

    wb_t         expQ[$];
    wb_t         monExp;
    int          checks = 0;
    int          errors = 0;
    int          ackDelay = 0;
    logic [31:0] memData = 32'h0;
    int          reqCycles = 0;
    int          lastReqLen = 0;
    logic [31:0] seenAddr, seenWdata;
    logic        seenWe;
    int          sc;

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
        end
    endtask

    // Memory model: acks on the ackDelay-th cycle of a request; 0 means never.
    always @(negedge clk) begin
        if (rst) begin
            reqCycles = 0;
            mem_ack   = 1'b0;
        end else if (mem_req) begin
            reqCycles++;
            lastReqLen = reqCycles;
            mem_ack    = (ackDelay != 0) && (reqCycles == ackDelay);
            mem_rdata  = mem_ack ? memData : 32'h0;
        end else begin
            reqCycles = 0;
            mem_ack   = 1'b0;
        end
    end

    // Monitor: every presented writeback must match the oldest expectation.
    always @(negedge clk) begin
        if (!rst && o_wbEn) begin
            if (expQ.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpectedWb: got writeback dir %0d data 0x%08h, expected none",
                         o_wbDir, o_wbData);
            end else begin
                monExp = expQ.pop_front();
                checkOutput("wbData", o_wbData, monExp.data);
                checkOutput("wbDir", 32'(o_wbDir), 32'(monExp.dir));
                checkOutput("wbCtrl", 32'(o_ctrl), 32'(monExp.ctrl));
                checkOutput("wbRobj", o_Robj, monExp.robj);
            end
        end
    end

    // Presents one instruction at a negedge, holds it while stalled, and
    // returns at the negedge after the accepting edge with a nop applied.
    task automatic applyStimulus(input logic [16:0] ctrl, input logic [31:0] alu,
                                 input logic [31:0] src, input logic [3:0] dir,
                                 input logic [31:0] robj, input int delay,
                                 input logic [31:0] rdata, output int stallCycles);
        wb_t  e;
        logic memOp;
        logic bubbleBad;
        memOp    = ctrl[0] | ctrl[1];
        ackDelay = delay;
        memData  = rdata;
        if (ctrl[2]) begin
            if (memOp && ctrl[3])
                e.data = (delay == 0 || delay > TIMEOUT) ? 32'h0 : rdata;
            else
                e.data = alu;
            e.dir  = dir;
            e.ctrl = ctrl;
            e.robj = robj;
            expQ.push_back(e);
        end
        i_ctrl = ctrl; i_alu = alu; i_srcReg = src; i_srcRegDir = dir; i_Robj = robj;
        #1;
        stallCycles = 0;
        bubbleBad   = 1'b0;
        while (o_stall && stallCycles < 50) begin
            stallCycles++;
            @(posedge clk);
            @(negedge clk);
            if (o_wbEn !== 1'b0) bubbleBad = 1'b1;
            if (stallCycles == 1) begin
                seenAddr  = 32'(mem_addr);
                seenWdata = mem_wdata;
                seenWe    = mem_we;
            end
        end
        if (memOp) checkOutput("bubbleWbEn", 32'(bubbleBad), 32'h0);
        @(posedge clk);
        @(negedge clk);
        checkOutput("wbEnTiming", 32'(o_wbEn), 32'(ctrl[2]));
        i_ctrl = '0; i_alu = '0; i_srcReg = '0; i_srcRegDir = '0; i_Robj = '0;
    endtask

    initial begin
        rst = 1'b1;
        i_ctrl = '0; i_alu = '0; i_srcReg = '0; i_srcRegDir = '0; i_Robj = '0;
        #1;
        checkOutput("rstMemReq", 32'(mem_req), 32'h0);
        checkOutput("rstMemWe", 32'(mem_we), 32'h0);
        checkOutput("rstMemAddr", 32'(mem_addr), 32'h0);
        checkOutput("rstMemWdata", mem_wdata, 32'h0);
        checkOutput("rstStall", 32'(o_stall), 32'h0);
        checkOutput("rstCtrl", 32'(o_ctrl), 32'h0);
        checkOutput("rstWbData", o_wbData, 32'h0);
        checkOutput("rstWbDir", 32'(o_wbDir), 32'h0);
        checkOutput("rstWbEn", 32'(o_wbEn), 32'h0);
        checkOutput("rstRobj", o_Robj, 32'h0);
        checkOutput("rstErr", 32'(o_err), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(17'h00004, 32'h12345678, 32'h0, 4'd5, 32'hA5A50001, 0, 32'h0, sc);
        checkOutput("aluStall", 32'(sc), 32'd0);

        applyStimulus(17'h0000D, 32'h00000040, 32'h0, 4'd3, 32'h00000111, 1, 32'hCAFEF00D, sc);
        checkOutput("loadStall", 32'(sc), 32'd2);
        checkOutput("loadAddr", seenAddr, 32'h40);
        checkOutput("loadWe", 32'(seenWe), 32'h0);

        applyStimulus(17'h10002, 32'h00000080, 32'hDEADBEEF, 4'd6, 32'h00000222, 4, 32'h0, sc);
        checkOutput("storeStall", 32'(sc), 32'd5);
        checkOutput("storeWe", 32'(seenWe), 32'h1);
        checkOutput("storeWdata", seenWdata, 32'hDEADBEEF);
        checkOutput("storeReqLen", 32'(lastReqLen), 32'd4);
        checkOutput("storeNoErr", 32'(o_err), 32'h0);

        applyStimulus(17'h00A0D, 32'h00000041, 32'h0, 4'd7, 32'h00000333, 2, 32'h11112222, sc);
        checkOutput("seqLoad1Stall", 32'(sc), 32'd3);
        applyStimulus(17'h00014, 32'h00003333, 32'h0, 4'd8, 32'h00000444, 0, 32'h0, sc);
        checkOutput("seqAluStall", 32'(sc), 32'd0);
        applyStimulus(17'h0000D, 32'h00000042, 32'h0, 4'd9, 32'h00000555, 1, 32'h44445555, sc);
        checkOutput("seqLoad2Stall", 32'(sc), 32'd2);

        applyStimulus(17'h0000D, 32'h00000050, 32'h0, 4'd10, 32'h00000666, 0, 32'hFFFFFFFF, sc);
        checkOutput("toStall", 32'(sc), 32'd5);
        checkOutput("toReqLen", 32'(lastReqLen), 32'd4);
        checkOutput("toErr", 32'(o_err), 32'h1);
        applyStimulus(17'h00004, 32'h00000777, 32'h0, 4'd11, 32'h00000777, 0, 32'h0, sc);
        checkOutput("errSticky", 32'(o_err), 32'h1);

        ackDelay = 0;
        i_ctrl = 17'h00001; i_alu = 32'h60; i_srcRegDir = 4'd12;
        @(posedge clk);
        @(negedge clk);
        @(posedge clk);
        #3;
        rst = 1'b1;
        i_ctrl = '0;
        #1;
        checkOutput("midRstReq", 32'(mem_req), 32'h0);
        checkOutput("midRstStall", 32'(o_stall), 32'h0);
        checkOutput("midRstErr", 32'(o_err), 32'h0);
        @(negedge clk);
        rst = 1'b0;

        applyStimulus(17'h00004, 32'h0000BEEF, 32'h0, 4'd2, 32'h00000888, 0, 32'h0, sc);
        checkOutput("recoverStall", 32'(sc), 32'd0);
        @(negedge clk);
        checkOutput("queueEmpty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
